hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32I core, placed directly downstream of the ID-stage decoder. It consumes the decoder's `rs1use`, `rs2use`, `hazard_optype` and `Branch` outputs together with the register indices of the instruction in ID. It keeps its own shadow copy of destination/optype for the EX and MEM stages, and from that produces:
- the stall and flush enables for the IF/ID/EX pipeline registers;
- the ID-stage forwarding selects;
- the EX-stage load-to-store data forward select.

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hz_stage_reg.sv | 23 ++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: optype classes,
// forward selects and the shadow-stage record.
package hazard_pkg;

  localparam int HZ_RAW = 5;

  typedef enum logic [1:0] {
    HZ_NONE  = 2'b00,
    HZ_STORE = 2'b01,
    HZ_ALU   = 2'b10,
    HZ_LOAD  = 2'b11
  } hz_optype_e;

  typedef enum logic [1:0] {
    FWD_RF       = 2'd0,
    FWD_EX_ALU   = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_DATA = 2'd3
  } hz_fwd_e;

  typedef struct packed {
    hz_optype_e        optype;
    logic [HZ_RAW-1:0] rd;
    logic [HZ_RAW-1:0] rs2;
  } hz_stage_t;

  // x0 is never a producer
  function automatic logic hz_writes(
    input hz_optype_e        op,
    input logic [HZ_RAW-1:0] rd
  );
    return (op == HZ_ALU || op == HZ_LOAD) && rd != '0;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One shadow pipeline stage: async clear, synchronous bubble.
// A bubble inserts an empty record (optype none).
module hz_stage_reg
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      bubble,
  input  hz_stage_t d,
  output hz_stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, branch flush and forward
// selects derived from a shadow copy of the EX/MEM stages.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              Branch_ID,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls
);

  hz_stage_t         id_d;
  hz_stage_t         ex_q;
  hz_stage_t         mem_q;
  logic [HZ_RAW-1:0] rs1_i;
  logic [HZ_RAW-1:0] rs2_i;
  logic              ex_ld;
  logic              stall;
  logic              unused_mem_rs2;

  function automatic hz_fwd_e fwd(
    input logic              en,
    input logic [HZ_RAW-1:0] rs,
    input hz_optype_e        ex_op,
    input logic [HZ_RAW-1:0] ex_rd,
    input hz_optype_e        mem_op,
    input logic [HZ_RAW-1:0] mem_rd
  );
    logic ex_hit;
    logic mem_hit;
    ex_hit  = en && ex_op == HZ_ALU
              && ex_rd != '0 && ex_rd == rs;
    mem_hit = en && !ex_hit
              && hz_writes(mem_op, mem_rd) && mem_rd == rs;
    unique case (1'b1)
      ex_hit:                      fwd = FWD_EX_ALU;
      mem_hit && mem_op == HZ_ALU: fwd = FWD_MEM_ALU;
      mem_hit && mem_op == HZ_LOAD: fwd = FWD_MEM_DATA;
      default:                     fwd = FWD_RF;
    endcase
  endfunction

  assign rs1_i = HZ_RAW'(rs1_ID);
  assign rs2_i = HZ_RAW'(rs2_ID);

  assign id_d = '{
    optype: hz_optype_e'(hazard_optype_ID),
    rd:     HZ_RAW'(rd_ID),
    rs2:    rs2_i
  };

  hz_stage_reg u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (reg_DE_flush),
    .d      (id_d),
    .q      (ex_q)
  );

  hz_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  assign unused_mem_rs2 = ^mem_q.rs2;

  // A store only stalls on its address operand; its data is
  // picked up later from MEM by forward_ctrl_ls.
  assign ex_ld = ex_q.optype == HZ_LOAD && ex_q.rd != '0;
  assign stall = ex_ld
    && ((rs1use_ID && rs1_i == ex_q.rd)
     || (rs2use_ID && rs2_i == ex_q.rd
         && id_d.optype != HZ_STORE));

  assign PC_EN_IF     = !stall;
  assign reg_FD_EN    = !stall;
  assign reg_DE_flush = stall;
  // Gated by reset so a stray branch cannot flush during reset
  assign reg_FD_flush = rst_n && Branch_ID && !stall;

  assign forward_ctrl_A = stall ? FWD_RF :
    fwd(rs1use_ID, rs1_i, ex_q.optype, ex_q.rd,
        mem_q.optype, mem_q.rd);

  assign forward_ctrl_B = stall ? FWD_RF :
    fwd(rs2use_ID, rs2_i, ex_q.optype, ex_q.rd,
        mem_q.optype, mem_q.rd);

  assign forward_ctrl_ls = ex_q.optype == HZ_STORE
    && mem_q.optype == HZ_LOAD
    && mem_q.rd != '0
    && ex_q.rs2 == mem_q.rd;

endmodule
